tlb_ptw_req_stage: RTL and testbench
====================================

Name: tlb_ptw_req_stage

Overview:
- Final registered stage of the L2 TLB lookup pipeline.
- Takes per-level page-table lookup results (hit / leaf / exception / entry / paddr).
- Picks the winning level with a priority selector plus encoder, and answers the requester with hit / error / exception.
- Sits between the TLB page arrays and the page-table walker: when nothing usable hits, it issues a walk request (CachePTWIO request side).

Parameters:
- PN_NUM, 2: number of page-table levels; index 0 = 4 KiB leaf level, highest index = top level.
- VADDR_SIZE, 32: virtual address width.
- PADDR_SIZE, 34: physical address width.
- PTE_BITS, 32: page-table entry width.
- INFO_W, 8: width of the opaque request info (TLBInfo) carried with the request.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  lookup result valid this cycle.
- req_error  in  1  request collided with a refill in the previous stage.
- req_vaddr  in  VADDR_SIZE  virtual address of the request.
- req_info  in  INFO_W  request info.
- flush  in  1  pipeline flush.
- lvl_hit  in  PN_NUM  per-level tag hit.
- lvl_leaf  in  PN_NUM  per-level entry is a leaf (r|w|x).
- lvl_exc  in  PN_NUM  per-level permission/format exception.
- lvl_entry  in  PN_NUM*PTE_BITS  per-level PTE, level i at bits [i*PTE_BITS +: PTE_BITS].
- lvl_paddr  in  PN_NUM*PADDR_SIZE  per-level generated paddr, same packing.
- ptw_full  in  1  walker cannot accept a request.
- hit  out  1  request resolved (translation, exception or error).
- error  out  1  request must be replayed.
- exception  out  1  page fault.
- hit_entry  out  PTE_BITS  selected PTE.
- hit_addr  out  VADDR_SIZE  registered req_vaddr.
- info_o  out  INFO_W  registered req_info.
- wpn  out  2  encoded winning level index.
- ptw_req  out  1  walk request.
- ptw_info  out  INFO_W  info sent to the walker.
- ptw_vaddr  out  VADDR_SIZE  vaddr sent to the walker.
- ptw_valid  out  PN_NUM  one-hot partial-hit level for the walker.
- ptw_paddr  out  PN_NUM*PADDR_SIZE  per-level paddr for the walker.
- refill_ready  out  1  constant 1.

Behaviour:
- Reset: while rst=0 (asynchronous), every registered output is 0. refill_ready is combinational 1 at all times.
- hit_first = priority select of lvl_hit: one-hot, lowest set index wins; all zeros if no hit.
- resolved = |(hit_first & (lvl_leaf | lvl_exc)).
- leaf_idx = index encoding of the lowest set bit of (lvl_hit & lvl_leaf). If none is set, leaf_idx = PN_NUM-1.
- Latency: all outputs register on the clock edge after inputs; 1 cycle.
  - hit <= req_valid & (resolved | ptw_full | req_error) & ~flush.
  - exception <= |(hit_first & lvl_exc). Not gated by req_valid; consumers qualify it with hit.
  - error <= (~resolved & ptw_full) | req_error. Not gated; qualify with hit.
  - hit_entry <= lvl_entry[leaf_idx].
  - wpn <= encoded index of hit_first, zero-extended to 2 bits; 0 when hit_first=0.
  - hit_addr <= req_vaddr; info_o <= req_info.
  - ptw_req <= req_valid & ~resolved & ~ptw_full & ~flush.
  - ptw_info <= req_info; ptw_vaddr <= req_vaddr; ptw_valid <= hit_first; ptw_paddr <= lvl_paddr.
- hit and ptw_req are mutually exclusive in any cycle, except when req_error=1 together with ~resolved & ~ptw_full: both assert. The walker drops the request via error replay.
- flush has priority: it suppresses both hit and ptw_req for that cycle. Data outputs still update.
- Non-leaf, non-exception hit (pointer PTE) with the walker free: ptw_req=1, hit=0, ptw_valid marks that level so the walk resumes from it.
- No state beyond the output registers. Reset mid-operation simply clears the outputs.

Decomposition:
- Shared package: level count, address widths, PTE_BITS, the info struct type.
- Sub-module prselector: lowest-set-bit one-hot, parameter WIDTH, combinational.
- Sub-module pencoder: one-hot/priority to binary index, parameter WIDTH.
- Both instantiated here. No other sub-modules.

Test Plan (PN_NUM=2):
- Leaf at level 0: req_valid=1, lvl_hit=01, lvl_leaf=01, lvl_exc=00 -> next cycle hit=1, error=0, exception=0, wpn=0, hit_entry=lvl_entry[0], ptw_req=0.
- Pointer at level 1, walker free: lvl_hit=10, lvl_leaf=00, lvl_exc=00, ptw_full=0 -> hit=0, ptw_req=1, ptw_valid=10, wpn=1, ptw_vaddr=req_vaddr.
- Miss with walker full: lvl_hit=00, ptw_full=1 -> hit=1, error=1, ptw_req=0.
- Exception at level 1 (superpage leaf with fault): lvl_hit=10, lvl_leaf=10, lvl_exc=10 -> hit=1, exception=1, wpn=1, hit_entry=lvl_entry[1].
- Flush and req_error: miss with flush=1 -> hit=0, ptw_req=0. Then req_error=1, req_valid=1, miss -> hit=1, error=1.
- Async reset: assert rst=0 mid-stream with hit=1 registered -> all outputs 0 immediately; refill_ready stays 1.

Source files
------------

// File: rtl/tlb_ptw_req_stage_pkg.sv
// Shared constants and types for the L2 TLB final lookup stage.
package tlb_ptw_req_stage_pkg;

  localparam int TLB_PN_NUM     = 2;   // page-table levels, 0 = 4 KiB leaf level
  localparam int TLB_VADDR_SIZE = 32;
  localparam int TLB_PADDR_SIZE = 34;
  localparam int TLB_PTE_BITS   = 32;
  localparam int TLB_INFO_W     = 8;

  // Opaque requester info travelling alongside a lookup.
  typedef struct packed {
    logic [TLB_INFO_W-1:0] bits;
  } tlb_info_t;

endpackage

// File: rtl/pencoder.sv
// Priority encoder: binary index of the lowest set bit, 0 when no bit is set.
module pencoder #(
  parameter int WIDTH = 2,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_bits,
  output logic [IDX_W-1:0] o_idx
);

  // Scan from the top down so the lowest set bit is written last and wins.
  always_comb begin
    // NOTE: default first so every path assigns o_idx and no latch is inferred.
    o_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_bits[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/prselector.sv
// Priority selector: keeps only the lowest set bit of the input (one-hot or zero).
module prselector #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] i_bits,
  output logic [WIDTH-1:0] o_onehot
);

  // x & -x isolates the lowest set bit; all zeros in gives all zeros out.
  assign o_onehot = i_bits & (~i_bits + WIDTH'(1));

endmodule

// File: rtl/tlb_ptw_req_stage.sv
// Final registered stage of the L2 TLB lookup: picks the winning level, answers
// the requester (hit / error / exception) or issues a page-table walk request.
module tlb_ptw_req_stage
  import tlb_ptw_req_stage_pkg::*;
#(
  parameter int PN_NUM     = TLB_PN_NUM,
  parameter int VADDR_SIZE = TLB_VADDR_SIZE,
  parameter int PADDR_SIZE = TLB_PADDR_SIZE,
  parameter int PTE_BITS   = TLB_PTE_BITS,
  parameter int INFO_W     = TLB_INFO_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  input  logic                         req_error,
  input  logic [VADDR_SIZE-1:0]        req_vaddr,
  input  logic [INFO_W-1:0]            req_info,
  input  logic                         flush,
  input  logic [PN_NUM-1:0]            lvl_hit,
  input  logic [PN_NUM-1:0]            lvl_leaf,
  input  logic [PN_NUM-1:0]            lvl_exc,
  input  logic [PN_NUM*PTE_BITS-1:0]   lvl_entry,
  input  logic [PN_NUM*PADDR_SIZE-1:0] lvl_paddr,
  input  logic                         ptw_full,
  output logic                         hit,
  output logic                         error,
  output logic                         exception,
  output logic [PTE_BITS-1:0]          hit_entry,
  output logic [VADDR_SIZE-1:0]        hit_addr,
  output logic [INFO_W-1:0]            info_o,
  output logic [1:0]                   wpn,
  output logic                         ptw_req,
  output logic [INFO_W-1:0]            ptw_info,
  output logic [VADDR_SIZE-1:0]        ptw_vaddr,
  output logic [PN_NUM-1:0]            ptw_valid,
  output logic [PN_NUM*PADDR_SIZE-1:0] ptw_paddr,
  output logic                         refill_ready
);

  localparam int IDX_W = (PN_NUM > 1) ? $clog2(PN_NUM) : 1;

  logic [PN_NUM-1:0]   w_hit_first;
  logic [PN_NUM-1:0]   w_leaf_hits;
  logic [IDX_W-1:0]    w_hit_idx;
  logic [IDX_W-1:0]    w_leaf_enc;
  logic [IDX_W-1:0]    w_leaf_idx;
  logic                w_resolved;
  logic                w_any_exc;
  logic [PTE_BITS-1:0] w_entries [PN_NUM];

  logic                         r_hit;
  logic                         r_error;
  logic                         r_exception;
  logic [PTE_BITS-1:0]          r_hit_entry;
  logic [VADDR_SIZE-1:0]        r_hit_addr;
  logic [INFO_W-1:0]            r_info;
  logic [1:0]                   r_wpn;
  logic                         r_ptw_req;
  logic [INFO_W-1:0]            r_ptw_info;
  logic [VADDR_SIZE-1:0]        r_ptw_vaddr;
  logic [PN_NUM-1:0]            r_ptw_valid;
  logic [PN_NUM*PADDR_SIZE-1:0] r_ptw_paddr;

  prselector #(.WIDTH(PN_NUM)) u_hit_sel (
    .i_bits   (lvl_hit),
    .o_onehot (w_hit_first)
  );

  pencoder #(.WIDTH(PN_NUM), .IDX_W(IDX_W)) u_hit_enc (
    .i_bits (w_hit_first),
    .o_idx  (w_hit_idx)
  );

  // Lowest hitting leaf supplies the PTE; fall back to the top level when none.
  assign w_leaf_hits = lvl_hit & lvl_leaf;

  pencoder #(.WIDTH(PN_NUM), .IDX_W(IDX_W)) u_leaf_enc (
    .i_bits (w_leaf_hits),
    .o_idx  (w_leaf_enc)
  );

  assign w_leaf_idx = (|w_leaf_hits) ? w_leaf_enc : IDX_W'(PN_NUM - 1);

  for (genvar g = 0; g < PN_NUM; g++) begin : g_entries
    assign w_entries[g] = lvl_entry[g*PTE_BITS +: PTE_BITS];
  end

  // A winning level that is a leaf or faults ends the lookup without a walk.
  assign w_resolved = |(w_hit_first & (lvl_leaf | lvl_exc));
  assign w_any_exc  = |(w_hit_first & lvl_exc);

  // Output registers; flush only masks the two request strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_hit       <= 1'b0;
      r_error     <= 1'b0;
      r_exception <= 1'b0;
      r_hit_entry <= '0;
      r_hit_addr  <= '0;
      r_info      <= '0;
      r_wpn       <= '0;
      r_ptw_req   <= 1'b0;
      r_ptw_info  <= '0;
      r_ptw_vaddr <= '0;
      r_ptw_valid <= '0;
      r_ptw_paddr <= '0;
    end else begin
      r_hit       <= req_valid & (w_resolved | ptw_full | req_error) & ~flush;
      r_error     <= (~w_resolved & ptw_full) | req_error;
      r_exception <= w_any_exc;
      r_hit_entry <= w_entries[w_leaf_idx];
      r_hit_addr  <= req_vaddr;
      r_info      <= req_info;
      r_wpn       <= 2'(w_hit_idx);
      r_ptw_req   <= req_valid & ~w_resolved & ~ptw_full & ~flush;
      r_ptw_info  <= req_info;
      r_ptw_vaddr <= req_vaddr;
      r_ptw_valid <= w_hit_first;
      r_ptw_paddr <= lvl_paddr;
    end
  end

  assign hit          = r_hit;
  assign error        = r_error;
  assign exception    = r_exception;
  assign hit_entry    = r_hit_entry;
  assign hit_addr     = r_hit_addr;
  assign info_o       = r_info;
  assign wpn          = r_wpn;
  assign ptw_req      = r_ptw_req;
  assign ptw_info     = r_ptw_info;
  assign ptw_vaddr    = r_ptw_vaddr;
  assign ptw_valid    = r_ptw_valid;
  assign ptw_paddr    = r_ptw_paddr;
  assign refill_ready = 1'b1;

endmodule

// File: tb/tb_tlb_ptw_req_stage.sv
// Directed bench for tlb_ptw_req_stage with the default two-level configuration.
module tb_tlb_ptw_req_stage;
  import tlb_ptw_req_stage_pkg::*;

  localparam int PN = TLB_PN_NUM;
  localparam int VA = TLB_VADDR_SIZE;
  localparam int PA = TLB_PADDR_SIZE;
  localparam int PT = TLB_PTE_BITS;
  localparam int IW = TLB_INFO_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               req_valid, req_error, flush, ptw_full;
  logic [VA-1:0]      req_vaddr;
  logic [IW-1:0]      req_info;
  logic [PN-1:0]      lvl_hit, lvl_leaf, lvl_exc;
  logic [PN*PT-1:0]   lvl_entry;
  logic [PN*PA-1:0]   lvl_paddr;
  logic               hit, error, exception, ptw_req, refill_ready;
  logic [PT-1:0]      hit_entry;
  logic [VA-1:0]      hit_addr, ptw_vaddr;
  logic [IW-1:0]      info_o, ptw_info;
  logic [1:0]         wpn;
  logic [PN-1:0]      ptw_valid;
  logic [PN*PA-1:0]   ptw_paddr;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [PT-1:0] E0 = 32'h1111_0001;
  localparam logic [PT-1:0] E1 = 32'h2222_0002;
  localparam logic [PA-1:0] P0 = 34'h1_0000_1000;
  localparam logic [PA-1:0] P1 = 34'h2_0040_0000;

  tlb_ptw_req_stage dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_error    (req_error),
    .req_vaddr    (req_vaddr),
    .req_info     (req_info),
    .flush        (flush),
    .lvl_hit      (lvl_hit),
    .lvl_leaf     (lvl_leaf),
    .lvl_exc      (lvl_exc),
    .lvl_entry    (lvl_entry),
    .lvl_paddr    (lvl_paddr),
    .ptw_full     (ptw_full),
    .hit          (hit),
    .error        (error),
    .exception    (exception),
    .hit_entry    (hit_entry),
    .hit_addr     (hit_addr),
    .info_o       (info_o),
    .wpn          (wpn),
    .ptw_req      (ptw_req),
    .ptw_info     (ptw_info),
    .ptw_vaddr    (ptw_vaddr),
    .ptw_valid    (ptw_valid),
    .ptw_paddr    (ptw_paddr),
    .refill_ready (refill_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one lookup at the falling edge, then sample just after the next rising edge.
  task automatic step(input logic v, input logic er, input logic fl, input logic full,
                      input logic [PN-1:0] h, input logic [PN-1:0] lf, input logic [PN-1:0] ex,
                      input logic [VA-1:0] va, input tlb_info_t inf);
    @(negedge clk);
    req_valid = v;  req_error = er; flush = fl; ptw_full = full;
    lvl_hit   = h;  lvl_leaf  = lf; lvl_exc = ex;
    req_vaddr = va; req_info  = inf.bits;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_error = 1'b0; flush = 1'b0; ptw_full = 1'b0;
    lvl_hit = '0; lvl_leaf = '0; lvl_exc = '0;
    req_vaddr = '0; req_info = '0;
    lvl_entry = {E1, E0};
    lvl_paddr = {P1, P0};

    // Reset state
    #12;
    check("rst_hit",       128'(hit), 128'(0));
    check("rst_ptw_req",   128'(ptw_req), 128'(0));
    check("rst_entry",     128'(hit_entry), 128'(0));
    check("rst_paddr",     128'(ptw_paddr), 128'(0));
    check("rst_refill",    128'(refill_ready), 128'(1));
    @(negedge clk);
    rst = 1'b1;

    // Leaf at level 0
    step(1, 0, 0, 0, 2'b01, 2'b01, 2'b00, 32'hA000_1000, '{bits: 8'h11});
    check("leaf0_hit",     128'(hit), 128'(1));
    check("leaf0_err",     128'(error), 128'(0));
    check("leaf0_exc",     128'(exception), 128'(0));
    check("leaf0_wpn",     128'(wpn), 128'(0));
    check("leaf0_entry",   128'(hit_entry), 128'(E0));
    check("leaf0_ptw_req", 128'(ptw_req), 128'(0));
    check("leaf0_addr",    128'(hit_addr), 128'(32'hA000_1000));
    check("leaf0_info",    128'(info_o), 128'(8'h11));

    // Pointer at level 1, walker free
    step(1, 0, 0, 0, 2'b10, 2'b00, 2'b00, 32'hB000_2000, '{bits: 8'h22});
    check("ptr1_hit",      128'(hit), 128'(0));
    check("ptr1_ptw_req",  128'(ptw_req), 128'(1));
    check("ptr1_valid",    128'(ptw_valid), 128'(2'b10));
    check("ptr1_wpn",      128'(wpn), 128'(1));
    check("ptr1_vaddr",    128'(ptw_vaddr), 128'(32'hB000_2000));
    check("ptr1_info",     128'(ptw_info), 128'(8'h22));
    check("ptr1_paddr",    128'(ptw_paddr), 128'({P1, P0}));
    check("ptr1_entry",    128'(hit_entry), 128'(E1));
    check("ptr1_err",      128'(error), 128'(0));

    // Miss with walker full
    step(1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 32'hC000_3000, '{bits: 8'h33});
    check("full_hit",      128'(hit), 128'(1));
    check("full_err",      128'(error), 128'(1));
    check("full_ptw_req",  128'(ptw_req), 128'(0));
    check("full_wpn",      128'(wpn), 128'(0));
    check("full_valid",    128'(ptw_valid), 128'(0));

    // Faulting superpage leaf at level 1
    step(1, 0, 0, 0, 2'b10, 2'b10, 2'b10, 32'hD000_4000, '{bits: 8'h44});
    check("exc1_hit",      128'(hit), 128'(1));
    check("exc1_exc",      128'(exception), 128'(1));
    check("exc1_wpn",      128'(wpn), 128'(1));
    check("exc1_entry",    128'(hit_entry), 128'(E1));
    check("exc1_ptw_req",  128'(ptw_req), 128'(0));
    check("exc1_err",      128'(error), 128'(0));

    // Both levels hit: level 0 is a pointer and wins, level 1 leaf supplies the PTE
    step(1, 0, 0, 0, 2'b11, 2'b10, 2'b00, 32'hE000_5000, '{bits: 8'h55});
    check("both_hit",      128'(hit), 128'(0));
    check("both_ptw_req",  128'(ptw_req), 128'(1));
    check("both_valid",    128'(ptw_valid), 128'(2'b01));
    check("both_wpn",      128'(wpn), 128'(0));
    check("both_entry",    128'(hit_entry), 128'(E1));

    // Flushed miss: strobes masked, data still updates
    step(1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 32'hF000_6000, '{bits: 8'h66});
    check("flush_hit",     128'(hit), 128'(0));
    check("flush_ptw_req", 128'(ptw_req), 128'(0));
    check("flush_addr",    128'(hit_addr), 128'(32'hF000_6000));

    // req_error on a miss with walker free: hit, error and ptw_req together
    step(1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 32'h1234_7000, '{bits: 8'h77});
    check("rerr_hit",      128'(hit), 128'(1));
    check("rerr_err",      128'(error), 128'(1));
    check("rerr_ptw_req",  128'(ptw_req), 128'(1));

    // Not valid: exception still registers, strobes stay low
    step(0, 0, 0, 0, 2'b01, 2'b01, 2'b01, 32'h5555_8000, '{bits: 8'h88});
    check("nv_hit",        128'(hit), 128'(0));
    check("nv_ptw_req",    128'(ptw_req), 128'(0));
    check("nv_exc",        128'(exception), 128'(1));

    // Asynchronous reset mid-stream
    step(1, 0, 0, 0, 2'b01, 2'b01, 2'b00, 32'h9999_9000, '{bits: 8'h99});
    check("pre_rst_hit",   128'(hit), 128'(1));
    #2;
    rst = 1'b0;
    #1;
    check("arst_hit",      128'(hit), 128'(0));
    check("arst_entry",    128'(hit_entry), 128'(0));
    check("arst_addr",     128'(hit_addr), 128'(0));
    check("arst_info",     128'(info_o), 128'(0));
    check("arst_vaddr",    128'(ptw_vaddr), 128'(0));
    check("arst_valid",    128'(ptw_valid), 128'(0));
    check("arst_refill",   128'(refill_ready), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
